// File: rtl/riscv_mul_sequencer.sv
// Multi-cycle sequencer between EX and a combinational XLEN x XLEN multiplier:
// holds registered operands for MUL_CYCLES cycles, stalls EX, and caches the last result.
module riscv_mul_sequencer #(
  parameter int MUL_CYCLES = 2,
  parameter int XLEN       = 64
) (
  input  logic            i_riscv_mulseq_clk,
  input  logic            i_riscv_mulseq_rst_n,
  input  logic            i_riscv_mulseq_valid,
  input  logic [2:0]      i_riscv_mulseq_mulctrl,
  input  logic            i_riscv_mulseq_wordop,
  input  logic [XLEN-1:0] i_riscv_mulseq_rs1data,
  input  logic [XLEN-1:0] i_riscv_mulseq_rs2data,
  input  logic            i_riscv_mulseq_flush,
  output logic            o_riscv_mulseq_stall,
  output logic            o_riscv_mulseq_done,
  output logic [XLEN-1:0] o_riscv_mulseq_result,
  output logic [XLEN-1:0] o_riscv_mulseq_mul_rs1,
  output logic [XLEN-1:0] o_riscv_mulseq_mul_rs2,
  output logic [2:0]      o_riscv_mulseq_mul_ctrl,
  input  logic [XLEN-1:0] i_riscv_mulseq_product
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;
  localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              w_q, w_d;
  logic [XLEN-1:0]   mul_rs1_q, mul_rs1_d, mul_rs2_q, mul_rs2_d;
  logic [2:0]        mul_ctrl_q, mul_ctrl_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              cache_vld_q, cache_vld_d;
  logic [XLEN-1:0]   cache_rs1_q, cache_rs1_d, cache_rs2_q, cache_rs2_d;
  logic [2:0]        cache_ctrl_q, cache_ctrl_d;
  logic              cache_w_q, cache_w_d;
  logic [XLEN-1:0]   cache_res_q, cache_res_d;

  logic req, w_in, hit, accept;
  logic [XLEN-1:0] final_product;

  assign req    = i_riscv_mulseq_valid & i_riscv_mulseq_mulctrl[2];
  assign w_in   = i_riscv_mulseq_wordop & (i_riscv_mulseq_mulctrl == 3'b100);
  assign accept = (state_q == S_IDLE) & req & ~i_riscv_mulseq_flush;
  assign hit    = cache_vld_q
                & (i_riscv_mulseq_rs1data == cache_rs1_q)
                & (i_riscv_mulseq_rs2data == cache_rs2_q)
                & (i_riscv_mulseq_mulctrl == cache_ctrl_q)
                & (w_in == cache_w_q);
  // MULW keeps the low word and sign-extends it to XLEN.
  assign final_product = w_q ? {{(XLEN-32){i_riscv_mulseq_product[31]}}, i_riscv_mulseq_product[31:0]}
                             : i_riscv_mulseq_product;

  always_ff @(posedge i_riscv_mulseq_clk or negedge i_riscv_mulseq_rst_n) begin
    if (!i_riscv_mulseq_rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      w_q          <= 1'b0;
      mul_rs1_q    <= '0;
      mul_rs2_q    <= '0;
      mul_ctrl_q   <= 3'b000;
      result_q     <= '0;
      cache_vld_q  <= 1'b0;
      // NOTE: the cache key/data are only qualified by cache_vld_q, but resetting them keeps
      // every output and compare deterministic out of reset for a handful of flops.
      cache_rs1_q  <= '0;
      cache_rs2_q  <= '0;
      cache_ctrl_q <= 3'b000;
      cache_w_q    <= 1'b0;
      cache_res_q  <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge value of every other flop.
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      w_q          <= w_d;
      mul_rs1_q    <= mul_rs1_d;
      mul_rs2_q    <= mul_rs2_d;
      mul_ctrl_q   <= mul_ctrl_d;
      result_q     <= result_d;
      cache_vld_q  <= cache_vld_d;
      cache_rs1_q  <= cache_rs1_d;
      cache_rs2_q  <= cache_rs2_d;
      cache_ctrl_q <= cache_ctrl_d;
      cache_w_q    <= cache_w_d;
      cache_res_q  <= cache_res_d;
    end
  end

  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (accept) state_d = hit ? S_DONE : S_BUSY;
      S_BUSY: begin
        if (i_riscv_mulseq_flush)  state_d = S_IDLE;
        else if (cnt_q == '0)      state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d        = cnt_q;
    w_d          = w_q;
    mul_rs1_d    = mul_rs1_q;
    mul_rs2_d    = mul_rs2_q;
    mul_ctrl_d   = mul_ctrl_q;
    result_d     = result_q;
    cache_vld_d  = cache_vld_q;
    cache_rs1_d  = cache_rs1_q;
    cache_rs2_d  = cache_rs2_q;
    cache_ctrl_d = cache_ctrl_q;
    cache_w_d    = cache_w_q;
    cache_res_d  = cache_res_q;
    if (accept) begin
      mul_rs1_d  = i_riscv_mulseq_rs1data;
      mul_rs2_d  = i_riscv_mulseq_rs2data;
      mul_ctrl_d = i_riscv_mulseq_mulctrl;
      w_d        = w_in;
      if (hit) result_d = cache_res_q;
      else     cnt_d    = CNT_W'(MUL_CYCLES - 1);
    end else if (state_q == S_BUSY && !i_riscv_mulseq_flush) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - 1'b1;
      end else begin
        result_d     = final_product;
        cache_vld_d  = 1'b1;
        cache_rs1_d  = mul_rs1_q;
        cache_rs2_d  = mul_rs2_q;
        cache_ctrl_d = mul_ctrl_q;
        cache_w_d    = w_q;
        cache_res_d  = final_product;
      end
    end
  end

  always_comb begin
    o_riscv_mulseq_stall = req & ~i_riscv_mulseq_flush & (state_q != S_DONE);
    o_riscv_mulseq_done  = (state_q == S_DONE);
  end

  assign o_riscv_mulseq_result   = result_q;
  assign o_riscv_mulseq_mul_rs1  = mul_rs1_q;
  assign o_riscv_mulseq_mul_rs2  = mul_rs2_q;
  assign o_riscv_mulseq_mul_ctrl = mul_ctrl_q;

endmodule
